ram_writer: RTL and testbench
=============================

# ram_writer

Sequential write-side master for the single-port RAM: accepts a burst of data words over a valid/ready stream and issues one RAM write per word. Write addresses come from an internal loadable up-counter (base address plus a fixed stride). It is the filling end of the RAM path; the read side is an address counter driving the RAM read port. Used by benches and system logic to preload RAM contents instead of poking memory arrays directly.

## Interface
- DATA_WIDTH, 8, width of one RAM word
- ADDR_WIDTH, 4, RAM address width (depth 2**ADDR_WIDTH)
- STRIDE, 4, address increment per written word, 1..2**ADDR_WIDTH-1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first write address, captured on accepted start
- count  in  ADDR_WIDTH+1  words in burst, 0..2**ADDR_WIDTH, captured on accepted start
- in_valid  in  1  in_data holds a word
- in_data  in  DATA_WIDTH  word to write
- in_ready  out  1  writer accepts a word this cycle
- we  out  1  RAM write enable, registered
- wr_addr  out  ADDR_WIDTH  RAM write address, registered
- wr_data  out  DATA_WIDTH  RAM write data, registered
- busy  out  1  high from accepted start until the last write is issued
- done  out  1  one-cycle pulse at burst end

## Operation
- States: IDLE, WRITE, FINISH.
- IDLE: in_ready=0, busy=0. start=1 and count!=0 -> load addr=base_addr, remaining=count, go WRITE. start=1 and count==0 -> go FINISH, no writes.
- WRITE: busy=1, in_ready=1 (combinational from state). Transfer = in_valid & in_ready. On transfer: next cycle we=1, wr_addr=addr, wr_data=in_data; addr <= (addr+STRIDE) mod 2**ADDR_WIDTH; remaining <= remaining-1. Transfer with remaining==1 -> go FINISH. No transfer -> we=0 next cycle, state and counters hold.
- FINISH: done=1 for exactly one cycle, in_ready=0, then IDLE.
- start outside IDLE is ignored; base_addr/count changes during a burst have no effect.
- Address arithmetic wraps modulo 2**ADDR_WIDTH; aliasing to an earlier address overwrites it, no error.
- remaining uses ADDR_WIDTH+1 bits so count=2**ADDR_WIDTH is legal.
- in_data is not checked; X data is written as-is.

## Timing
- Reset values: in_ready=0, we=0, wr_addr=0, wr_data=0, busy=0, done=0, state IDLE.
- start accepted at edge N -> in_ready=1 in cycle N+1.
- Transfer at edge K -> we/wr_addr/wr_data valid in cycle K+1 (one-cycle latency); RAM captures at edge K+1.
- Last transfer at edge K -> last write in cycle K+1, done=1 in cycle K+1, busy=0 from cycle K+1; in_ready=0 from cycle K+1.
- Throughput: one word per cycle with in_valid held high; burst of n words takes n+1 cycles from first transfer to done.
- count==0: start at edge N -> done=1 in cycle N+1, we never asserted.
- Reset mid-burst: outputs reset immediately (asynchronous), burst abandoned, writes already issued remain in RAM, done not pulsed.

## Structure
- Shared package ram_pkg: state encoding constants (IDLE, WRITE, FINISH), default DATA_WIDTH/ADDR_WIDTH.
- Sub-module addr_counter: ADDR_WIDTH-bit register with synchronous load (base_addr), enable, and parameterised STRIDE increment, async active-high reset; reusable by the read-side address generator.
- FSM, remaining counter and output registers stay in ram_writer.

## Test plan
- Basic burst: base=0, count=4, STRIDE=4, data 3,7,1,9 back-to-back -> writes (0,3),(4,7),(8,1),(12,9) in consecutive cycles, done one cycle with last write.
- Backpressure gaps: same burst, in_valid low 2 cycles between words -> we only in cycles after transfers, addresses still 0,4,8,12, done after 4th.
- Wrap-around: base=12, count=3, STRIDE=4 -> addresses 12,0,4.
- count=0 and ignored start: start count=0 -> done next cycle, no we; start pulsed mid-burst -> no effect on addresses or remaining.
- Full depth: base=1, count=16, STRIDE=1 -> 16 writes at 1..15,0, busy high throughout, done once.
- Reset mid-burst: assert reset after 2 of 4 words -> all outputs 0 immediately, state IDLE, next start runs a clean burst from new base.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM fill/read path: state encoding and default widths.
package ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ram_writer_if.sv
// Control, input stream and RAM write-port bundle of the RAM writer.
interface ram_writer_if import ram_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;

  // Side that requests bursts and supplies words.
  modport master (
    output start, base_addr, count, in_valid, in_data,
    input  in_ready, we, wr_addr, wr_data, busy, done
  );

  // The writer itself.
  modport slave (
    input  start, base_addr, count, in_valid, in_data,
    output in_ready, we, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/addr_counter.sv
// Loadable address up-counter with a fixed stride; wraps modulo 2**ADDR_WIDTH.
module addr_counter import ram_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] load_val,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);

  logic [ADDR_WIDTH-1:0] addr_d, addr_q;

  // Load has priority over advance; natural overflow gives the wrap.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (en) begin
      addr_d = addr_q + STEP;
    end
  end

  // Address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/ram_writer.sv
// Burst writer: takes words from a valid/ready stream and issues one registered
// RAM write per word at base, base+STRIDE, ... (wrapping).
//
//   state  | meaning
//   IDLE   | waiting for start, in_ready low
//   WRITE  | accepting words, one write issued per transfer
//   FINISH | one-cycle done pulse, then back to IDLE
module ram_writer import ram_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int STRIDE     = 4
) (
  input logic         clk,
  input logic         reset,
  ram_writer_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] REM_ONE = 1;

  wr_state_e             state_d, state_q;
  logic [ADDR_WIDTH:0]   remaining_d, remaining_q;
  logic                  we_d, we_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  addr_load, addr_adv, xfer;
  logic [ADDR_WIDTH-1:0] addr;

  addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRIDE     (STRIDE)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (addr_load),
    .en       (addr_adv),
    .load_val (bus.base_addr),
    .addr     (addr)
  );

  assign xfer = bus.in_valid && (state_q == WRITE);

  // Next-state, burst bookkeeping and next value of every registered output.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    addr_load   = 1'b0;
    addr_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            addr_load   = 1'b1;
            remaining_d = bus.count;
            state_d     = WRITE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      WRITE: begin
        if (xfer) begin
          we_d        = 1'b1;
          wr_addr_d   = addr;
          wr_data_d   = bus.in_data;
          addr_adv    = 1'b1;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags track the state being entered so they line up with it.
    busy_d = (state_d == WRITE);
    done_d = (state_d == FINISH);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready = (state_q == WRITE);
  assign bus.we       = we_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_writer.sv
// Drives two writers (STRIDE 4 and STRIDE 1) with identical stimulus and checks
// every write, its cycle, and the done/busy timing against an arithmetic model.
module tb_ram_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] count;
  logic       in_valid;
  logic [7:0] in_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t got4[$];
  wr_t got1[$];
  int  dn4 = 0, dn1 = 0;
  int  dcyc4 = 0, dcyc1 = 0;
  int  dbusy4 = 0, dbusy1 = 0;

  logic [7:0] words[16];

  always #5 clk = ~clk;

  ram_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus4 ();
  ram_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

  assign bus4.start     = start;
  assign bus4.base_addr = base_addr;
  assign bus4.count     = count;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus1.start     = start;
  assign bus1.base_addr = base_addr;
  assign bus1.count     = count;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;

  ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STRIDE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STRIDE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus4.we === 1'b1) got4.push_back('{int'(bus4.wr_addr), int'(bus4.wr_data), cyc});
    if (bus1.we === 1'b1) got1.push_back('{int'(bus1.wr_addr), int'(bus1.wr_data), cyc});
    if (bus4.done === 1'b1) begin
      dn4    <= dn4 + 1;
      dcyc4  <= cyc;
      dbusy4 <= int'(bus4.busy);
    end
    if (bus1.done === 1'b1) begin
      dn1    <= dn1 + 1;
      dcyc1  <= cyc;
      dbusy1 <= int'(bus1.busy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready4"}, 32'(bus4.in_ready), 0);
    chk({tag, "_we4"},       32'(bus4.we), 0);
    chk({tag, "_wr_addr4"},  32'(bus4.wr_addr), 0);
    chk({tag, "_wr_data4"},  32'(bus4.wr_data), 0);
    chk({tag, "_busy4"},     32'(bus4.busy), 0);
    chk({tag, "_done4"},     32'(bus4.done), 0);
    chk({tag, "_in_ready1"}, 32'(bus1.in_ready), 0);
    chk({tag, "_we1"},       32'(bus1.we), 0);
    chk({tag, "_wr_addr1"},  32'(bus1.wr_addr), 0);
    chk({tag, "_wr_data1"},  32'(bus1.wr_data), 0);
    chk({tag, "_busy1"},     32'(bus1.busy), 0);
    chk({tag, "_done1"},     32'(bus1.done), 0);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
  endtask

  // Compare one writer's burst against the model: address (base + i*stride) mod 16,
  // data words[i], write i in cycle acc + i*(gap+1) + 1, done with the last write.
  task automatic check_dut(input string nm, input int sel, input int stride, input int b,
                           input int cnt, input int gap, input int acc, input int n0, input int d0);
    wr_t q[$];
    int  dn, dc, db, exp_done;
    if (sel == 0) begin
      q = got4; dn = dn4; dc = dcyc4; db = dbusy4;
    end else begin
      q = got1; dn = dn1; dc = dcyc1; db = dbusy1;
    end
    chk({nm, "_n_writes"}, q.size() - n0, cnt);
    for (int i = 0; i < cnt && n0 + i < q.size(); i++) begin
      chk($sformatf("%s_wr_addr[%0d]", nm, i), q[n0+i].addr, (b + i * stride) % 16);
      chk($sformatf("%s_wr_data[%0d]", nm, i), q[n0+i].data, int'(words[i]));
      chk($sformatf("%s_wr_cycle[%0d]", nm, i), q[n0+i].cyc, acc + i * (gap + 1) + 1);
    end
    exp_done = (cnt == 0) ? acc : acc + (cnt - 1) * (gap + 1) + 1;
    chk({nm, "_done_count"}, dn - d0, 1);
    chk({nm, "_done_cycle"}, dc, exp_done);
    chk({nm, "_busy_at_done"}, db, 0);
  endtask

  // One burst on both writers; gap = idle cycles between words, mid = pulse a
  // conflicting start in the middle of the burst.
  task automatic run_burst(input int b, input int cnt, input int gap, input bit mid);
    int n04, n01, d04, d01, acc, i, guard, gapn, bbad;
    bit pulsed;
    n04 = got4.size(); n01 = got1.size(); d04 = dn4; d01 = dn1;
    @(negedge clk);
    base_addr = 4'(b); count = 5'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    i = 0; guard = 0; gapn = 0; bbad = 0; pulsed = 1'b0;
    while (i < cnt && guard < 300) begin
      if (gapn > 0) begin
        in_valid = 1'b0;
        gapn--;
      end else begin
        in_valid = 1'b1;
        in_data  = words[i];
        if (bus4.in_ready === 1'b1) begin
          i++;
          gapn = gap;
        end
      end
      if (mid && i == 2 && !pulsed) begin
        start = 1'b1; base_addr = 4'd7; count = 5'd1; pulsed = 1'b1;
      end
      if (bus4.in_ready === 1'b1 && bus4.busy !== 1'b1) bbad++;
      if (bus1.in_ready === 1'b1 && bus1.busy !== 1'b1) bbad++;
      @(negedge clk);
      guard++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("burst_completed", i, cnt);
    chk("busy_during_burst", bbad, 0);
    check_dut("s4", 0, 4, b, cnt, gap, acc, n04, d04);
    check_dut("s1", 1, 1, b, cnt, gap, acc, n01, d01);
    chk("idle_in_ready", 32'({bus4.in_ready, bus1.in_ready}), 0);
    chk("idle_busy", 32'({bus4.busy, bus1.busy}), 0);
  endtask

  initial begin
    int n04, n01, d04, d01;
    reset = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0; in_data = '0;
    #1 reset = 1'b1;
    #1 chk_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    words[0] = 8'd3; words[1] = 8'd7; words[2] = 8'd1; words[3] = 8'd9;
    run_burst(0, 4, 0, 1'b0);
    run_burst(0, 4, 2, 1'b0);
    fill_rand();
    run_burst(12, 3, 0, 1'b0);
    run_burst(9, 0, 0, 1'b0);
    fill_rand();
    run_burst(3, 4, 0, 1'b1);
    fill_rand();
    run_burst(1, 16, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_burst(int'($urandom_range(15, 0)), int'($urandom_range(16, 1)),
                int'($urandom_range(2, 0)), 1'b0);
    end

    // Reset after two of four words.
    fill_rand();
    n04 = got4.size(); n01 = got1.size(); d04 = dn4; d01 = dn1;
    @(negedge clk);
    base_addr = 4'd0; count = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = words[0];
    @(negedge clk);
    in_data = words[1];
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_we", 32'({bus4.we, bus1.we}), 3);
    #2 reset = 1'b1;
    #1 chk_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_n_writes4", got4.size() - n04, 2);
    chk("rst_n_writes1", got1.size() - n01, 2);
    if (got4.size() >= n04 + 2) chk("rst_addr4", 32'({got4[n04].addr[7:0], got4[n04+1].addr[7:0]}), 32'h0004);
    if (got1.size() >= n01 + 2) chk("rst_addr1", 32'({got1[n01].addr[7:0], got1[n01+1].addr[7:0]}), 32'h0001);
    chk("rst_no_done", (dn4 - d04) + (dn1 - d01), 0);
    chk("rst_idle", 32'({bus4.in_ready, bus4.busy, bus1.in_ready, bus1.busy}), 0);
    fill_rand();
    run_burst(5, 4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
